// File: rtl/lotr_pkg.sv
// -----------------------------------------------------------------------------
// lotr_pkg
//   Shared types and constants for the UART command controller.
//
//   t_opcode    : fabric request/response opcode (RD, WR, RD_RSP, WR_RSP)
//   t_cmd_state : command FSM state
//   CMD_*       : ASCII command bytes accepted on the RX path
//   RPL_*       : ASCII single-byte replies sent on the TX path
//   REPLY_LEN_* : reply lengths handed to the TX serializer
// -----------------------------------------------------------------------------
package lotr_pkg;

   typedef enum logic [1:0] {
      RD     = 2'b00,
      WR     = 2'b01,
      RD_RSP = 2'b10,
      WR_RSP = 2'b11
   } t_opcode;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      GET_ADDR = 3'd1,
      GET_DATA = 3'd2,
      ISSUE    = 3'd3,
      WAIT_RSP = 3'd4,
      SEND     = 3'd5
   } t_cmd_state;

   localparam logic [7:0] CMD_WRITE   = 8'h57;  // 'W'
   localparam logic [7:0] CMD_READ    = 8'h52;  // 'R'
   localparam logic [7:0] RPL_ACK     = 8'h4B;  // 'K'
   localparam logic [7:0] RPL_BAD     = 8'h3F;  // '?'
   localparam logic [7:0] RPL_TIMEOUT = 8'h54;  // 'T'

   localparam logic [2:0] REPLY_LEN_BYTE = 3'd1;
   localparam logic [2:0] REPLY_LEN_WORD = 3'd4;

   // The serializer always sends from bits [31:24] downwards, so a
   // single-byte reply sits in the top lane.
   function automatic logic [31:0] single_byte_reply(input logic [7:0] b);
      return {b, 24'h000000};
   endfunction

endpackage

// File: rtl/uart_cmd_tx_ser.sv
// -----------------------------------------------------------------------------
// uart_cmd_tx_ser
//   Reply serializer: loads a 1..4 byte reply and hands it to the UART TX
//   path one byte at a time, most significant byte first.
//
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous reset, active low
//   load      in   one-cycle strobe: capture load_word/load_len and start
//   load_word in   reply bytes, first byte in [31:23+1]
//   load_len  in   number of bytes to send (1..4)
//   tx_ready  in   UART TX can accept the byte on tx_data
//   tx_valid  out  byte on tx_data is valid
//   tx_data   out  current reply byte
//   done      out  combinational pulse on the handshake of the last byte
//
//   tx_valid rises the cycle after load and drops the cycle after the
//   last handshake.
// -----------------------------------------------------------------------------
module uart_cmd_tx_ser (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] load_word,
   input  logic [2:0]  load_len,
   input  logic        tx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   output logic        done
);

   logic [7:0]  lane [4];
   logic        tx_valid_reg;
   logic [7:0]  tx_data_reg;
   logic [23:0] pend_reg;     // bytes still to send after tx_data_reg
   logic [1:0]  remain_reg;   // count of bytes in pend_reg, never above 3
   logic        handshake;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lane[gi] = load_word[31 - 8*gi -: 8];
      end
   endgenerate

   assign handshake = tx_valid_reg && tx_ready;
   assign done      = handshake && (remain_reg == 2'd0);
   assign tx_valid  = tx_valid_reg;
   assign tx_data   = tx_data_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_valid_reg <= 1'b0;
         tx_data_reg  <= 8'h00;
         pend_reg     <= 24'h000000;
         remain_reg   <= 2'd0;
      end else if (load) begin
         tx_valid_reg <= 1'b1;
         tx_data_reg  <= lane[0];
         pend_reg     <= {lane[1], lane[2], lane[3]};
         remain_reg   <= 2'(load_len - 3'd1);
      end else if (handshake) begin
         if (remain_reg == 2'd0) begin
            tx_valid_reg <= 1'b0;
            tx_data_reg  <= 8'h00;
         end else begin
            tx_data_reg <= pend_reg[23:16];
            pend_reg    <= {pend_reg[15:0], 8'h00};
            remain_reg  <= remain_reg - 2'd1;
         end
      end
   end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_cmd_ctrl
//   Turns ASCII commands received over a UART into fabric requests and
//   sends the result back over the UART.
//
//     'W' a3 a2 a1 a0 d3 d2 d1 d0  -> WR request, reply 'K'
//     'R' a3 a2 a1 a0              -> RD request, reply 4 data bytes MSB first
//     any other first byte         -> reply '?'
//
//   Parameters
//     THREAD_ID       thread ID driven on every request
//     TIMEOUT_CYCLES  read-response wait limit (only with the macro below)
//
//   Build option
//     UART_CMD_TIMEOUT_EN : when defined, a read that gets no RD_RSP within
//                           TIMEOUT_CYCLES cycles is answered with 'T'.
//                           When undefined, reads wait indefinitely.
//
//   Ports
//     QClk, RstQnnnL            clock (rising edge), async active-low reset
//     RxValid, RxData           received byte (one-cycle pulse)
//     TxValid, TxData, TxReady  reply byte handshake toward UART TX
//     C2F_Req*Q500H             fabric request
//     C2F_Rsp*Q502H             fabric response
//     C2F_RspStall              request backpressure (accept when low)
//     CmdBusy                   high whenever the FSM is not IDLE
//     RxDropped                 one-cycle pulse per byte discarded while
//                               issuing, waiting or replying
// -----------------------------------------------------------------------------
module uart_cmd_ctrl
   import lotr_pkg::*;
#(
   parameter logic [1:0]  THREAD_ID      = 2'd0,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
   input  logic        QClk,
   input  logic        RstQnnnL,
   input  logic        RxValid,
   input  logic [7:0]  RxData,
   output logic        TxValid,
   output logic [7:0]  TxData,
   input  logic        TxReady,
   output logic        C2F_ReqValidQ500H,
   output t_opcode     C2F_ReqOpcodeQ500H,
   output logic [31:0] C2F_ReqAddressQ500H,
   output logic [31:0] C2F_ReqDataQ500H,
   output logic [1:0]  C2F_ReqThreadIDQ500H,
   input  logic        C2F_RspValidQ502H,
   input  t_opcode     C2F_RspOpcodeQ502H,
   input  logic [31:0] C2F_RspDataQ502H,
   input  logic        C2F_RspStall,
   output logic        CmdBusy,
   output logic        RxDropped
);

   t_cmd_state  state_reg;
   logic [1:0]  byte_cnt_reg;
   logic [31:0] addr_reg;
   logic [31:0] data_reg;
   t_opcode     opcode_reg;
   logic        req_valid_reg;
   logic [1:0]  tid_reg;
   logic        busy_reg;
   logic        rx_dropped_reg;

   logic        rx_is_cmd;
   logic        rd_rsp_hit;
   logic        req_accept;
   logic        ser_load;
   logic [31:0] ser_word;
   logic [2:0]  ser_len;
   logic        ser_done;
   logic        timeout_hit;

   assign rx_is_cmd  = (RxData == CMD_WRITE) || (RxData == CMD_READ);
   assign rd_rsp_hit = C2F_RspValidQ502H && (C2F_RspOpcodeQ502H == RD_RSP);
   // req_valid_reg is only ever high in ISSUE.
   assign req_accept = req_valid_reg && !C2F_RspStall;

`ifdef UART_CMD_TIMEOUT_EN
   // Cycles spent in WAIT_RSP; restarts from 0 on every entry.
   logic [31:0] wait_cnt_reg;

   assign timeout_hit = (wait_cnt_reg == (TIMEOUT_CYCLES - 32'd1));

   always_ff @(posedge QClk or negedge RstQnnnL) begin
      if (!RstQnnnL) begin
         wait_cnt_reg <= 32'd0;
      end else if (state_reg == WAIT_RSP) begin
         wait_cnt_reg <= wait_cnt_reg + 32'd1;
      end else begin
         wait_cnt_reg <= 32'd0;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Every event that enters SEND loads the serializer in the same cycle,
   // so TxValid rises on the very next cycle.
   always_comb begin
      ser_load = 1'b0;
      ser_word = 32'h0000_0000;
      ser_len  = REPLY_LEN_BYTE;
      case (state_reg)
         IDLE: begin
            if (RxValid && !rx_is_cmd) begin
               ser_load = 1'b1;
               ser_word = single_byte_reply(RPL_BAD);
            end
         end
         ISSUE: begin
            if (req_accept && (opcode_reg == WR)) begin
               ser_load = 1'b1;
               ser_word = single_byte_reply(RPL_ACK);
            end
         end
         WAIT_RSP: begin
            if (rd_rsp_hit) begin
               ser_load = 1'b1;
               ser_word = C2F_RspDataQ502H;
               ser_len  = REPLY_LEN_WORD;
            end else if (timeout_hit) begin
               ser_load = 1'b1;
               ser_word = single_byte_reply(RPL_TIMEOUT);
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge QClk or negedge RstQnnnL) begin
      if (!RstQnnnL) begin
         state_reg      <= IDLE;
         byte_cnt_reg   <= 2'd0;
         addr_reg       <= 32'h0000_0000;
         data_reg       <= 32'h0000_0000;
         opcode_reg     <= RD;
         req_valid_reg  <= 1'b0;
         tid_reg        <= 2'd0;
         busy_reg       <= 1'b0;
         rx_dropped_reg <= 1'b0;
      end else begin
         rx_dropped_reg <= RxValid && ((state_reg == ISSUE) ||
                                       (state_reg == WAIT_RSP) ||
                                       (state_reg == SEND));
         case (state_reg)
            IDLE: begin
               if (RxValid) begin
                  // Every byte in IDLE leaves IDLE: either a command or a '?' reply.
                  busy_reg     <= 1'b1;
                  byte_cnt_reg <= 2'd0;
                  if (rx_is_cmd) begin
                     opcode_reg <= (RxData == CMD_WRITE) ? WR : RD;
                     // Clearing data here makes a read carry data 0.
                     addr_reg   <= 32'h0000_0000;
                     data_reg   <= 32'h0000_0000;
                     state_reg  <= GET_ADDR;
                  end else begin
                     state_reg  <= SEND;
                  end
               end
            end
            GET_ADDR: begin
               if (RxValid) begin
                  addr_reg <= {addr_reg[23:0], RxData};
                  if (byte_cnt_reg == 2'd3) begin
                     byte_cnt_reg <= 2'd0;
                     if (opcode_reg == WR) begin
                        state_reg <= GET_DATA;
                     end else begin
                        state_reg     <= ISSUE;
                        req_valid_reg <= 1'b1;
                        tid_reg       <= THREAD_ID;
                     end
                  end else begin
                     byte_cnt_reg <= byte_cnt_reg + 2'd1;
                  end
               end
            end
            GET_DATA: begin
               if (RxValid) begin
                  data_reg <= {data_reg[23:0], RxData};
                  if (byte_cnt_reg == 2'd3) begin
                     byte_cnt_reg  <= 2'd0;
                     state_reg     <= ISSUE;
                     req_valid_reg <= 1'b1;
                     tid_reg       <= THREAD_ID;
                  end else begin
                     byte_cnt_reg <= byte_cnt_reg + 2'd1;
                  end
               end
            end
            ISSUE: begin
               // Payload registers do not change here, so they stay
               // stable for as long as stall holds the request.
               if (!C2F_RspStall) begin
                  req_valid_reg <= 1'b0;
                  state_reg     <= (opcode_reg == WR) ? SEND : WAIT_RSP;
               end
            end
            WAIT_RSP: begin
               if (ser_load) begin
                  state_reg <= SEND;
               end
            end
            SEND: begin
               if (ser_done) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   uart_cmd_tx_ser u_tx_ser (
      .clk       (QClk),
      .rst_n     (RstQnnnL),
      .load      (ser_load),
      .load_word (ser_word),
      .load_len  (ser_len),
      .tx_ready  (TxReady),
      .tx_valid  (TxValid),
      .tx_data   (TxData),
      .done      (ser_done)
   );

   assign C2F_ReqValidQ500H    = req_valid_reg;
   assign C2F_ReqOpcodeQ500H   = opcode_reg;
   assign C2F_ReqAddressQ500H  = addr_reg;
   assign C2F_ReqDataQ500H     = data_reg;
   assign C2F_ReqThreadIDQ500H = tid_reg;
   assign CmdBusy              = busy_reg;
   assign RxDropped            = rx_dropped_reg;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_ctrl
//   Directed bench for uart_cmd_ctrl: a table of complete commands with
//   hand-computed requests and replies, plus hand-written sequences for
//   reset values, reply latency, dropped bytes, reset mid-command and the
//   read-response wait (timeout with UART_CMD_TIMEOUT_EN, unbounded without).
// -----------------------------------------------------------------------------
module tb_uart_cmd_ctrl;
   import lotr_pkg::*;

   logic        QClk = 1'b0;
   logic        RstQnnnL = 1'b0;
   logic        RxValid = 1'b0;
   logic [7:0]  RxData = 8'h00;
   logic        TxValid;
   logic [7:0]  TxData;
   logic        TxReady = 1'b1;
   logic        C2F_ReqValidQ500H;
   t_opcode     C2F_ReqOpcodeQ500H;
   logic [31:0] C2F_ReqAddressQ500H;
   logic [31:0] C2F_ReqDataQ500H;
   logic [1:0]  C2F_ReqThreadIDQ500H;
   logic        C2F_RspValidQ502H = 1'b0;
   t_opcode     C2F_RspOpcodeQ502H = RD;
   logic [31:0] C2F_RspDataQ502H = 32'h0;
   logic        C2F_RspStall = 1'b0;
   logic        CmdBusy;
   logic        RxDropped;

   always #5 QClk = ~QClk;

   uart_cmd_ctrl #(
      .THREAD_ID      (2'd2),
      .TIMEOUT_CYCLES (32'd50)
   ) dut (
      .QClk                 (QClk),
      .RstQnnnL             (RstQnnnL),
      .RxValid              (RxValid),
      .RxData               (RxData),
      .TxValid              (TxValid),
      .TxData               (TxData),
      .TxReady              (TxReady),
      .C2F_ReqValidQ500H    (C2F_ReqValidQ500H),
      .C2F_ReqOpcodeQ500H   (C2F_ReqOpcodeQ500H),
      .C2F_ReqAddressQ500H  (C2F_ReqAddressQ500H),
      .C2F_ReqDataQ500H     (C2F_ReqDataQ500H),
      .C2F_ReqThreadIDQ500H (C2F_ReqThreadIDQ500H),
      .C2F_RspValidQ502H    (C2F_RspValidQ502H),
      .C2F_RspOpcodeQ502H   (C2F_RspOpcodeQ502H),
      .C2F_RspDataQ502H     (C2F_RspDataQ502H),
      .C2F_RspStall         (C2F_RspStall),
      .CmdBusy              (CmdBusy),
      .RxDropped            (RxDropped)
   );

   // ---------------- monitors: accepted requests, TX bytes, drops ----------
   typedef struct {
      t_opcode     op;
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  tid;
   } req_t;

   req_t       req_q[$];
   logic [7:0] tx_q[$];
   int         drop_cnt = 0;

   always @(posedge QClk) begin
      if (C2F_ReqValidQ500H && !C2F_RspStall)
         req_q.push_back('{op: C2F_ReqOpcodeQ500H, addr: C2F_ReqAddressQ500H,
                           data: C2F_ReqDataQ500H, tid: C2F_ReqThreadIDQ500H});
      if (TxValid && TxReady) tx_q.push_back(TxData);
      if (RxDropped) drop_cnt++;
   end

   // ---------------- checking helpers --------------------------------------
   int n_cmp  = 0;
   int n_fail = 0;
   bit tx_throttle = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // All stimulus tasks start and end 1 time unit after a rising edge.
   task automatic tick();
      @(posedge QClk);
      #1;
      if (tx_throttle) TxReady = ~TxReady;
   endtask

   task automatic send_byte(input logic [7:0] b);
      RxValid = 1'b1;
      RxData  = b;
      tick();
      RxValid = 1'b0;
      RxData  = 8'h00;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
   endtask

   task automatic respond(input t_opcode op, input logic [31:0] d);
      C2F_RspValidQ502H  = 1'b1;
      C2F_RspOpcodeQ502H = op;
      C2F_RspDataQ502H   = d;
      tick();
      C2F_RspValidQ502H  = 1'b0;
      C2F_RspOpcodeQ502H = RD;
      C2F_RspDataQ502H   = 32'h0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n;
      n = 0;
      while (CmdBusy && n < budget) begin
         tick();
         n++;
      end
      if (CmdBusy) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: CmdBusy still 1 after %0d cycles, expected 0", name, budget);
      end
   endtask

   task automatic check_tx(input string name, input int tx0, input int exp_n, input logic [31:0] exp_bytes);
      int n;
      n = tx_q.size() - tx0;
      check({name, "_tx_count"}, n, exp_n);
      for (int i = 0; i < n && i < exp_n; i++)
         check($sformatf("%s_tx_byte%0d", name, i), 32'(tx_q[tx0 + i]),
               32'(exp_bytes[8*(exp_n - 1 - i) +: 8]));
   endtask

   // ---------------- vector table ------------------------------------------
   typedef struct {
      logic [7:0]  cmd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rsp;
      int          stall;      // cycles the request is held off
      bit          ign;        // send a WR_RSP before the RD_RSP
      bit          throttle;   // toggle TxReady every cycle
      int          exp_nreq;
      t_opcode     exp_op;
      logic [31:0] exp_addr;
      logic [31:0] exp_data;
      int          exp_ntx;
      logic [31:0] exp_tx;     // reply bytes, right-aligned, first byte highest
   } vec_t;

   vec_t vecs[8];

   task automatic run_vec(input int idx, input vec_t v);
      int    rq0, tx0, nreq;
      bit    is_cmd;
      string nm;
      nm     = $sformatf("v%0d", idx);
      rq0    = req_q.size();
      tx0    = tx_q.size();
      is_cmd = (v.cmd == 8'h57) || (v.cmd == 8'h52);
      tx_throttle  = v.throttle;
      C2F_RspStall = (v.stall > 0);
      send_byte(v.cmd);
      if (is_cmd) begin
         send_word(v.addr);
         if (v.cmd == 8'h57) send_word(v.wdata);
         for (int s = 0; s < v.stall; s++) begin
            check({nm, "_stall_valid"}, 32'(C2F_ReqValidQ500H), 32'd1);
            check({nm, "_stall_addr"}, C2F_ReqAddressQ500H, v.exp_addr);
            check({nm, "_stall_data"}, C2F_ReqDataQ500H, v.exp_data);
            tick();
         end
         C2F_RspStall = 1'b0;
         if (v.cmd == 8'h52) begin
            tick();
            if (v.ign) respond(WR_RSP, 32'hBAD0_BAD0);
            respond(RD_RSP, v.rsp);
         end
      end
      wait_idle(200, {nm, "_idle"});
      tx_throttle = 1'b0;
      TxReady     = 1'b1;
      nreq = req_q.size() - rq0;
      check({nm, "_req_count"}, nreq, v.exp_nreq);
      if (nreq >= 1 && v.exp_nreq == 1) begin
         check({nm, "_req_op"},   32'(req_q[rq0].op), 32'(v.exp_op));
         check({nm, "_req_addr"}, req_q[rq0].addr, v.exp_addr);
         check({nm, "_req_data"}, req_q[rq0].data, v.exp_data);
         check({nm, "_req_tid"},  32'(req_q[rq0].tid), 32'd2);
      end
      check_tx(nm, tx0, v.exp_ntx, v.exp_tx);
      $display("txn %0d: cmd=0x%02h requests=%0d tx_bytes=%0d", idx, v.cmd, nreq,
               tx_q.size() - tx0);
   endtask

   // ---------------- main sequence -----------------------------------------
   initial begin
      int rq0, tx0, d0, n;

      vecs[0] = '{8'h57, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0,          0, 1'b0, 1'b0,
                  1, WR, 32'h0000_1004, 32'hDEAD_BEEF, 1, 32'h4B};
      vecs[1] = '{8'h52, 32'h0000_2000, 32'h0,          32'h1234_5678, 0, 1'b0, 1'b0,
                  1, RD, 32'h0000_2000, 32'h0,          4, 32'h1234_5678};
      vecs[2] = '{8'h57, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0,          5, 1'b0, 1'b1,
                  1, WR, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h4B};
      vecs[3] = '{8'h52, 32'h8000_0001, 32'h0,          32'hA5C3_0F96, 1, 1'b1, 1'b1,
                  1, RD, 32'h8000_0001, 32'h0,          4, 32'hA5C3_0F96};
      vecs[4] = '{8'h41, 32'h0,          32'h0,          32'h0,          0, 1'b0, 1'b0,
                  0, RD, 32'h0,          32'h0,          1, 32'h3F};
      vecs[5] = '{8'h52, 32'h0000_0000, 32'h0,          32'h0000_0000, 2, 1'b0, 1'b0,
                  1, RD, 32'h0000_0000, 32'h0,          4, 32'h0000_0000};
      vecs[6] = '{8'h77, 32'h0,          32'h0,          32'h0,          0, 1'b0, 1'b1,
                  0, RD, 32'h0,          32'h0,          1, 32'h3F};
      vecs[7] = '{8'h57, 32'h1234_5678, 32'h00C0_FFEE, 32'h0,          0, 1'b0, 1'b1,
                  1, WR, 32'h1234_5678, 32'h00C0_FFEE, 1, 32'h4B};

      // Reset values
      tick();
      tick();
      check("rst_tx_valid",  32'(TxValid), 32'd0);
      check("rst_tx_data",   32'(TxData), 32'd0);
      check("rst_req_valid", 32'(C2F_ReqValidQ500H), 32'd0);
      check("rst_req_op",    32'(C2F_ReqOpcodeQ500H), 32'(RD));
      check("rst_req_addr",  C2F_ReqAddressQ500H, 32'd0);
      check("rst_req_data",  C2F_ReqDataQ500H, 32'd0);
      check("rst_req_tid",   32'(C2F_ReqThreadIDQ500H), 32'd0);
      check("rst_busy",      32'(CmdBusy), 32'd0);
      check("rst_dropped",   32'(RxDropped), 32'd0);
      RstQnnnL = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

      // Bad command: reply latency, byte dropped during the reply, TxValid drop
      tx0 = tx_q.size();
      rq0 = req_q.size();
      d0  = drop_cnt;
      TxReady = 1'b0;
      send_byte(8'h41);
      check("bad_latency_valid", 32'(TxValid), 32'd1);
      check("bad_latency_data",  32'(TxData), 32'h3F);
      send_byte(8'h57);
      tick();
      check("drop_count",     drop_cnt - d0, 32'd1);
      check("drop_pulse_end", 32'(RxDropped), 32'd0);
      check("bad_tx_held",    32'(TxValid), 32'd1);
      TxReady = 1'b1;
      tick();
      check("bad_tx_dropped", 32'(TxValid), 32'd0);
      check("bad_busy_clear", 32'(CmdBusy), 32'd0);
      check("bad_no_request", req_q.size() - rq0, 32'd0);
      check_tx("bad", tx0, 1, 32'h3F);
      $display("txn bad: cmd=0x41 tx_bytes=%0d dropped=%0d", tx_q.size() - tx0, drop_cnt - d0);

      // Reset after two address bytes, then a full read
      rq0 = req_q.size();
      tx0 = tx_q.size();
      send_byte(8'h52);
      send_byte(8'hAA);
      send_byte(8'hBB);
      RstQnnnL = 1'b0;
      #1;
      check("midrst_busy",      32'(CmdBusy), 32'd0);
      check("midrst_req_valid", 32'(C2F_ReqValidQ500H), 32'd0);
      tick();
      tick();
      RstQnnnL = 1'b1;
      tick();
      send_byte(8'h52);
      send_word(32'h0000_3000);
      tick();
      respond(RD_RSP, 32'h0BAD_CAFE);
      wait_idle(100, "midrst_idle");
      check("midrst_req_count", req_q.size() - rq0, 32'd1);
      if (req_q.size() > rq0) check("midrst_req_addr", req_q[rq0].addr, 32'h0000_3000);
      check_tx("midrst", tx0, 4, 32'h0BAD_CAFE);
      $display("txn midrst: requests=%0d tx_bytes=%0d", req_q.size() - rq0, tx_q.size() - tx0);

      // Read with no prompt response
      tx0 = tx_q.size();
      send_byte(8'h52);
      send_word(32'h0000_4000);
      tick();
`ifdef UART_CMD_TIMEOUT_EN
      n = 0;
      while (!TxValid && n < 200) begin
         tick();
         n++;
      end
      check("timeout_cycles", n, 32'd50);
      check("timeout_byte",   32'(TxData), 32'h54);
      wait_idle(20, "timeout_idle");
      respond(RD_RSP, 32'h1111_2222);
      repeat (20) tick();
      check("timeout_late_busy", 32'(CmdBusy), 32'd0);
      check_tx("timeout", tx0, 1, 32'h54);
`else
      n = 0;
      repeat (300) begin
         tick();
         n++;
      end
      check("wait_no_tx", 32'(TxValid), 32'd0);
      check("wait_busy",  32'(CmdBusy), 32'd1);
      respond(RD_RSP, 32'hCAFE_F00D);
      wait_idle(50, "wait_idle");
      check_tx("wait", tx0, 4, 32'hCAFE_F00D);
`endif
      $display("txn wait: waited=%0d tx_bytes=%0d", n, tx_q.size() - tx0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within 500000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter THREAD_ID, default 2'd0, the thread ID driven on every issued request.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 32'd100000, the read-response wait limit in QClk cycles.
REQ-003 SHALL have port QClk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port RstQnnnL, input, 1 bit, the reset: asynchronous assert, active-low.
REQ-005 SHALL have RxValid, input, 1 bit (one-cycle pulse) and RxData, input, 8 bits: a byte received from the UART RX path.
REQ-006 SHALL have TxValid, output, 1 bit; TxData, output, 8 bits; TxReady, input, 1 bit: a byte handed to UART TX when TxValid and TxReady are both high.
REQ-007 SHALL have C2F_ReqValidQ500H, output, 1; C2F_ReqOpcodeQ500H, output, t_opcode; C2F_ReqAddressQ500H, output, 32; C2F_ReqDataQ500H, output, 32; C2F_ReqThreadIDQ500H, output, 2: the fabric request.
REQ-008 SHALL have C2F_RspValidQ502H, input, 1; C2F_RspOpcodeQ502H, input, t_opcode; C2F_RspDataQ502H, input, 32; C2F_RspStall, input, 1: the fabric response and backpressure.
REQ-009 SHALL have CmdBusy, output, 1 (high when not IDLE) and RxDropped, output, 1 (one-cycle pulse per discarded byte).

Function
REQ-010 SHALL implement FSM states IDLE, GET_ADDR, GET_DATA, ISSUE, WAIT_RSP, SEND.
REQ-011 IDLE: byte 0x57 ('W') -> GET_ADDR (write); 0x52 ('R') -> GET_ADDR (read); any other byte -> queue 0x3F ('?') as a single-byte reply in SEND.
REQ-012 GET_ADDR SHALL collect 4 bytes MSB first (first byte -> addr[31:24]), then go to GET_DATA for a write or ISSUE for a read.
REQ-013 GET_DATA SHALL collect 4 bytes MSB first, then go to ISSUE.
REQ-014 ISSUE SHALL drive C2F_ReqValidQ500H high with opcode WR or RD, address, data (read data = 0) and THREAD_ID.
REQ-015 ISSUE handshake: the request is accepted in the first cycle C2F_RspStall is low; while stall is high the valid and payload SHALL be held stable.
REQ-016 Request valid SHALL be high for exactly one accepted cycle; after acceptance a write goes to SEND with reply 0x4B ('K') and a read goes to WAIT_RSP.
REQ-017 WAIT_RSP SHALL capture C2F_RspDataQ502H on the cycle C2F_RspValidQ502H is high and C2F_RspOpcodeQ502H==RD_RSP, then go to SEND with a 4-byte reply, MSB first.
REQ-018 WAIT_RSP SHALL ignore responses with any other opcode.
REQ-019 SEND SHALL present one byte at a time on TxValid/TxData and advance on TxValid&&TxReady; after the last byte it returns to IDLE and TxValid drops the next cycle.
REQ-020 RxValid in ISSUE, WAIT_RSP or SEND SHALL discard the byte and pulse RxDropped; a byte counter SHALL never wrap past 3.
REQ-021 RxValid and a TX handshake in the same cycle SHALL follow REQ-020 and REQ-019 independently.
REQ-022 Reply latency: TxValid SHALL rise one cycle after the event that enters SEND.

Reset
REQ-023 While RstQnnnL is low: state = IDLE, byte counters = 0, and TxValid, TxData, C2F_ReqValidQ500H, C2F_ReqAddressQ500H, C2F_ReqDataQ500H, C2F_ReqThreadIDQ500H, CmdBusy and RxDropped are all 0; C2F_ReqOpcodeQ500H = RD.
REQ-024 Reset mid-command SHALL abandon the command with no request and no reply emitted after deassertion.

Configuration
REQ-025 With UART_CMD_TIMEOUT_EN defined, WAIT_RSP SHALL count cycles; at TIMEOUT_CYCLES with no RD_RSP it goes to SEND with single reply 0x54 ('T') and a late response is ignored.
REQ-026 Without UART_CMD_TIMEOUT_EN, WAIT_RSP SHALL wait indefinitely and no counter logic is present.

Structure
REQ-027 The command bytes ('W','R','K','?','T') and the FSM state enum SHALL be defined in lotr_pkg; t_opcode SHALL come from lotr_pkg.
REQ-028 The reply serializer (up to 4-byte load, MSB-first TX handshake) SHALL be a sub-module named uart_cmd_tx_ser.

Verification
REQ-029 Write: send 'W',00,00,10,04,DE,AD,BE,EF -> one request WR, addr 0x00001004, data 0xDEADBEEF, TID THREAD_ID; then TX byte 0x4B.
REQ-030 Read: send 'R',00,00,20,00; respond RD_RSP 0x12345678 -> TX bytes 12,34,56,78 in order, then CmdBusy = 0.
REQ-031 Stall: hold C2F_RspStall high for 5 cycles during ISSUE -> valid and payload stable for 5 cycles, single accept on cycle 6.
REQ-032 Bad command: byte 0x41 -> TX 0x3F, no request; a byte arriving during the reply -> RxDropped pulses once.
REQ-033 Timeout (macro on, TIMEOUT_CYCLES=50): read with no response -> TX 0x54 after 50 cycles; a later RD_RSP produces no TX.
REQ-034 Reset after 2 address bytes, then a full 'R' command -> exactly one request, using only the post-reset address.
